// File: rtl/ram_pkg.sv
// Shared constants and clear-FSM state encoding for the dual-port clearable RAM.
package ram_pkg;

    localparam int DEF_ADDR_BITS = 9;
    localparam int DEF_DATA_BITS = 8;
    localparam int DEF_LANES     = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } clr_state_t;

endpackage

// File: rtl/ram_lane.sv
// One lane of storage: single write port, asynchronous read port.
module ram_lane #(
    parameter int ADDR_BITS = 9,
    parameter int WIDTH     = 8
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output logic [WIDTH-1:0]     rd_data
);

    logic [WIDTH-1:0] mem [2**ADDR_BITS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/ram_dp_clr.sv
// Dual-port lane-writable RAM with a sequential whole-array clear.
// Define RAM_OUT_REG_EN for a second output register stage (latency 2).
module ram_dp_clr
    import ram_pkg::*;
#(
    parameter int                        ADDR_BITS = DEF_ADDR_BITS,
    parameter int                        DATA_BITS = DEF_DATA_BITS,
    parameter int                        LANES     = DEF_LANES,
    parameter logic [DATA_BITS-1:0]      CLR_VALUE = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_n,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [LANES-1:0]     wr_lane_en,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 rd_en,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 clr_start,
    output logic                 clr_busy,
    output logic                 clr_done
);

    localparam int                   LW   = DATA_BITS / LANES;
    localparam logic [ADDR_BITS-1:0] LAST = '1;

    clr_state_t           state;
    clr_state_t           state_nxt;
    logic [ADDR_BITS-1:0] cnt;
    logic                 user_wr;
    logic [DATA_BITS-1:0] rd_word;

    always_comb begin
        state_nxt = state;
        clr_busy  = 1'b0;
        clr_done  = 1'b0;
        unique case (state)
            IDLE: begin
                if (clr_start) state_nxt = CLEAR;
            end
            CLEAR: begin
                clr_busy = 1'b1;
                if (cnt == LAST) state_nxt = DONE;
            end
            DONE: begin
                clr_done  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A clear request in IDLE takes priority over a coincident write.
    assign user_wr = !wr_n && (state != CLEAR) &&
                     !((state == IDLE) && clr_start);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE) begin
                cnt <= '0;
            end else if (state == CLEAR) begin
                cnt <= cnt + ADDR_BITS'(1);
            end
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic          we;
        logic [ADDR_BITS-1:0] addr;
        logic [LW-1:0] wdata;
        logic [LW-1:0] arr;
        logic          fwd;

        // Reset stops the clear before the current entry is touched.
        assign we    = clr_busy ? !rst : (user_wr && wr_lane_en[i]);
        assign addr  = clr_busy ? cnt : wr_addr;
        assign wdata = clr_busy ? CLR_VALUE[i*LW +: LW] : data_in[i*LW +: LW];
        assign fwd   = user_wr && wr_lane_en[i] && (wr_addr == rd_addr);

        assign rd_word[i*LW +: LW] = clr_busy ? CLR_VALUE[i*LW +: LW] :
                                     fwd      ? data_in[i*LW +: LW]   : arr;

        ram_lane #(
            .ADDR_BITS(ADDR_BITS),
            .WIDTH    (LW)
        ) u_lane (
            .clk    (clk),
            .we     (we),
            .wr_addr(addr),
            .wr_data(wdata),
            .rd_addr(rd_addr),
            .rd_data(arr)
        );
    end

    logic [DATA_BITS-1:0] q1;
    logic                 v1;

    always_ff @(posedge clk) begin
        if (rst) begin
            q1 <= '0;
            v1 <= 1'b0;
        end else begin
            v1 <= rd_en;
            if (rd_en) q1 <= rd_word;
        end
    end

`ifdef RAM_OUT_REG_EN
    logic [DATA_BITS-1:0] q2;
    logic                 v2;

    always_ff @(posedge clk) begin
        if (rst) begin
            q2 <= '0;
            v2 <= 1'b0;
        end else begin
            v2 <= v1;
            if (v1) q2 <= q1;
        end
    end

    assign data_out   = q2;
    assign data_valid = v2;
`else
    assign data_out   = q1;
    assign data_valid = v1;
`endif

endmodule

// File: tb/tb_ram_dp_clr.sv
// Scoreboard bench for ram_dp_clr: behavioural array/FSM model, expected reads queued
// at issue and compared when their latency expires.
module tb_ram_dp_clr;

    localparam int          AB  = 4;
    localparam int          DB  = 16;
    localparam int          LN  = 2;
    localparam logic [15:0] CLR = 16'h00FF;
`ifdef RAM_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic          clk;
    logic          rst;
    logic          wr_n;
    logic [AB-1:0] wr_addr;
    logic [LN-1:0] wr_lane_en;
    logic [DB-1:0] data_in;
    logic          rd_en;
    logic [AB-1:0] rd_addr;
    logic [DB-1:0] data_out;
    logic          data_valid;
    logic          clr_start;
    logic          clr_busy;
    logic          clr_done;

    ram_dp_clr #(
        .ADDR_BITS(AB),
        .DATA_BITS(DB),
        .LANES    (LN),
        .CLR_VALUE(CLR)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_n      (wr_n),
        .wr_addr   (wr_addr),
        .wr_lane_en(wr_lane_en),
        .data_in   (data_in),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .data_out  (data_out),
        .data_valid(data_valid),
        .clr_start (clr_start),
        .clr_busy  (clr_busy),
        .clr_done  (clr_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [15:0] d;
    } rd_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc_n = 0;
    int          m_st  = 0;
    logic [3:0]  m_cnt = '0;
    logic [15:0] m_mem [16];
    logic [15:0] last  = '0;
    rd_t         q[$];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc_n);
        end
    endtask

    function automatic logic [15:0] merge(input logic [15:0] old,
                                          input logic [1:0] en,
                                          input logic [15:0] d);
        logic [15:0] r;
        r = old;
        if (en[0]) r[7:0]  = d[7:0];
        if (en[1]) r[15:8] = d[15:8];
        return r;
    endfunction

    task automatic step(input logic rs, input logic wn, input logic [3:0] wa,
                        input logic [1:0] le, input logic [15:0] di,
                        input logic re, input logic [3:0] ra, input logic cs);
        logic wr_eff;
        rd_t  r;
        rst = rs; wr_n = wn; wr_addr = wa; wr_lane_en = le;
        data_in = di; rd_en = re; rd_addr = ra; clr_start = cs;
        wr_eff = !wn && (m_st != 1) && !((m_st == 0) && cs);
        if (re && !rs) begin
            r.due = cyc_n + LAT;
            if (m_st == 1) r.d = CLR;
            else r.d = merge(m_mem[ra], (wr_eff && wa == ra) ? le : 2'b00, di);
            q.push_back(r);
        end
        if (rs) begin
            if (wr_eff) m_mem[wa] = merge(m_mem[wa], le, di);
            m_st = 0; m_cnt = '0; last = '0;
            q.delete();
        end else begin
            case (m_st)
                0: begin
                    if (cs) begin m_st = 1; m_cnt = '0; end
                    else if (wr_eff) m_mem[wa] = merge(m_mem[wa], le, di);
                end
                1: begin
                    m_mem[m_cnt] = CLR;
                    if (m_cnt == 4'hF) m_st = 2;
                    m_cnt = m_cnt + 4'd1;
                end
                default: begin
                    if (wr_eff) m_mem[wa] = merge(m_mem[wa], le, di);
                    m_st = 0;
                end
            endcase
        end
        @(posedge clk);
        #1;
        cyc_n++;
        check("clr_busy", 32'(clr_busy), 32'(m_st == 1));
        check("clr_done", 32'(clr_done), 32'(m_st == 2));
        if (q.size() > 0 && q[0].due == cyc_n) begin
            r = q.pop_front();
            check("data_valid", 32'(data_valid), 32'd1);
            check("data_out", 32'(data_out), 32'(r.d));
            last = r.d;
        end else begin
            check("data_valid_idle", 32'(data_valid), 32'd0);
            check("data_out_hold", 32'(data_out), 32'(last));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 1, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic wr(input logic [3:0] a, input logic [1:0] le, input logic [15:0] d);
        step(0, 0, a, le, d, 0, 0, 0);
    endtask

    task automatic rd(input logic [3:0] a);
        step(0, 1, 0, 0, 0, 1, a, 0);
    endtask

    initial begin
        step(1, 1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 1, 3, 0);
        idle(2);

        // full clear; write, read and re-trigger issued mid-clear
        step(0, 1, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 16; i++) begin
            if (i == 3) step(0, 1, 0, 0, 0, 0, 0, 1);
            else if (i == 6) step(0, 0, 4'd9, 2'b11, 16'hDEAD, 1, 4'd9, 0);
            else if (i == 10) step(0, 1, 0, 0, 0, 1, 4'd2, 0);
            else idle(1);
        end
        step(0, 1, 0, 0, 0, 0, 0, 1);
        idle(1);
        for (int a = 0; a < 16; a++) rd(4'(a));
        idle(2);

        wr(4'd3, 2'b11, 16'h005A);
        rd(4'd3);
        idle(2);

        wr(4'd7, 2'b11, 16'h1234);
        wr(4'd7, 2'b01, 16'hABCD);
        rd(4'd7);

        wr(4'd5, 2'b11, 16'h0011);
        step(0, 0, 4'd5, 2'b11, 16'h0077, 1, 4'd5, 0);
        step(0, 0, 4'd5, 2'b10, 16'hBEEF, 1, 4'd5, 0);
        rd(4'd5);
        idle(3);

        for (int i = 0; i < 150; i++) begin
            step(0, 1'($urandom_range(0, 1)), 4'($urandom), 2'($urandom),
                 16'($urandom), 1'($urandom_range(0, 1)), 4'($urandom), 0);
        end
        idle(2);

        for (int a = 0; a < 16; a++) wr(4'(a), 2'b11, 16'(16'h4100 + a));
        // clear request and write together: the write to 12 must vanish
        step(0, 0, 4'd12, 2'b11, 16'h9999, 0, 0, 1);
        for (int i = 0; i < 5; i++) idle(1);
        step(1, 1, 0, 0, 0, 0, 0, 0);
        idle(2);
        for (int a = 0; a < 16; a++) rd(4'(a));
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ram_dp_clr.md
RAM_DP_CLR -- requirements
Module: ram_dp_clr

Interface
REQ-001 Parameter ADDR_BITS, default 9: address width; depth is 2**ADDR_BITS entries.
REQ-002 Parameter DATA_BITS, default 8: entry width; SHALL be a multiple of LANES.
REQ-003 Parameter LANES, default 1: number of independently writable lanes of DATA_BITS/LANES bits each.
REQ-004 Parameter CLR_VALUE, default 0: DATA_BITS-wide value written to every entry by a clear.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 wr_n  in  1  write strobe, active low.
REQ-008 wr_addr  in  ADDR_BITS  write address.
REQ-009 wr_lane_en  in  LANES  per-lane write enable, qualified by wr_n.
REQ-010 data_in  in  DATA_BITS  write data.
REQ-011 rd_en  in  1  read request.
REQ-012 rd_addr  in  ADDR_BITS  read address.
REQ-013 data_out  out  DATA_BITS  read data.
REQ-014 data_valid  out  1  data_out holds a newly completed read.
REQ-015 clr_start  in  1  request to clear the whole array.
REQ-016 clr_busy  out  1  clear in progress.
REQ-017 clr_done  out  1  one-cycle pulse when a clear completes.

Function
REQ-018 Write: when wr_n=0 and clr_busy=0, each lane i with wr_lane_en[i]=1 SHALL be updated from data_in at the clock edge; other lanes SHALL keep their contents.
REQ-019 Read latency SHALL be 1 cycle: rd_en=1 at edge N gives data_out and data_valid=1 after edge N+1; data_valid=0 after any edge with rd_en=0.
REQ-020 data_out SHALL hold its last value while rd_en=0.
REQ-021 Same-cycle read and write to the same address SHALL return write-first data: enabled lanes from data_in, other lanes from the array.
REQ-022 Clear FSM states: IDLE, CLEAR, DONE.
REQ-023 IDLE -> CLEAR on clr_start=1; a ADDR_BITS-wide counter SHALL be loaded with 0.
REQ-024 In CLEAR, one entry per cycle SHALL be written with CLR_VALUE at the counter address; the counter SHALL increment; after writing entry 2**ADDR_BITS-1 the FSM SHALL go to DONE; a full clear takes exactly 2**ADDR_BITS cycles.
REQ-025 DONE SHALL last one cycle with clr_done=1 and then return to IDLE.
REQ-026 clr_busy SHALL be 1 exactly while the FSM is in CLEAR.
REQ-027 clr_start while in CLEAR or DONE SHALL be ignored.
REQ-028 While clr_busy=1, wr_n SHALL be ignored, and reads SHALL return CLR_VALUE with data_valid asserted as in REQ-019.
REQ-029 If clr_start and wr_n=0 coincide in IDLE, the clear SHALL win and the write SHALL be dropped.
REQ-030 Address counter and read/write addresses SHALL wrap modulo 2**ADDR_BITS; no out-of-range access exists.

Reset
REQ-031 rst=1 SHALL force data_out=0, data_valid=0, clr_busy=0, clr_done=0, FSM=IDLE, and counter=0 on the next edge.
REQ-032 Array contents SHALL NOT be affected by rst; only a clear initialises them.
REQ-033 rst during CLEAR SHALL abort the clear with no clr_done pulse, leaving entries already cleared at CLR_VALUE and the remaining entries unchanged.

Configuration
REQ-034 With macro RAM_OUT_REG_EN defined, a second output register SHALL be added: read latency becomes 2, data_valid is delayed to match, and the reset value of both stages is 0.
REQ-035 Without RAM_OUT_REG_EN, latency SHALL be 1 per REQ-019; all other behaviour is identical.

Structure
REQ-036 Package ram_pkg SHALL hold the clear FSM state enumeration (IDLE, CLEAR, DONE) and the default parameter constants.
REQ-037 The per-lane storage array SHALL be a sub-module ram_lane (one write enable, width DATA_BITS/LANES), instantiated LANES times; the FSM, forwarding and output registers SHALL stay in the top level.

Verification
REQ-038 ADDR_BITS=4, DATA_BITS=8: write 0x5A to address 3, read address 3 the next cycle -> data_out=0x5A, data_valid=1 one cycle after rd_en.
REQ-039 LANES=2, DATA_BITS=16: address 7 holds 0x1234; write 0xABCD with wr_lane_en=2'b01 -> reading address 7 returns 0x12CD.
REQ-040 Same-cycle write of 0x77 and read of address 5 (old value 0x11) -> data_out=0x77.
REQ-041 ADDR_BITS=4, CLR_VALUE=0xFF: pulse clr_start -> clr_busy high for 16 cycles, clr_done a single pulse, all 16 entries read 0xFF; a write issued mid-clear is dropped.
REQ-042 rst asserted at clear cycle 5 -> clr_busy=0 next edge, no clr_done, entries 0..4 read CLR_VALUE and entries 5..15 keep their old data.
REQ-043 With RAM_OUT_REG_EN: write then read address 2 -> data_out and data_valid appear 2 cycles after rd_en.
